mux_nch_stream: RTL
===================

Name: mux_nch_stream

Overview:
- Parametrised N-channel, WIDTH-bit multiplexer with a registered output stage and valid/ready handshakes on every input channel and on the output.
- Two selection modes:
  - Mode 0: fixed select, driven by the sel port.
  - Mode 1: fair round-robin across channels that present valid data.
- Replaces single-bit combinational 2:1 selection wherever data sources share one downstream consumer.
- Sits between multiple producer blocks and a single sink in the lab datapath.

Parameters:
- WIDTH, 8: data bits per channel.
- NCH, 4: number of input channels; legal range 2..16.
- SEL_W, 2: select/channel-index width; must equal ceil(log2(NCH)).

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- mode  input  1  0 = fixed select via sel; 1 = round-robin.
- sel  input  SEL_W  channel selected in mode 0; ignored in mode 1.
- in_data  input  NCH*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  input  NCH  per-channel valid.
- in_ready  output  NCH  per-channel ready; combinational.
- out_data  output  WIDTH  registered output data.
- out_ch  output  SEL_W  index of the channel whose data is in out_data.
- out_valid  output  1  output register holds a word.
- out_ready  input  1  sink accepts the word this cycle.

Behaviour:
- Reset (rst=1 at a clk edge):
  - out_valid=0, out_data=0, out_ch=0, round-robin pointer rr_ptr=0.
  - rst overrides any concurrent transfer.
  - A word in flight at reset is dropped.
  - in_ready is all zero while rst=1.
- can_load = !out_valid | out_ready. The output register is empty, or it is being drained this same cycle.
- Grant channel g, combinational:
  - Mode 0: g = sel.
  - Mode 1: g = first index j with in_valid[j]=1, scanning j = rr_ptr, rr_ptr+1, ... with wrap modulo NCH.
  - Mode 1 with no in_valid set: no grant; in_ready stays all zero.
- in_ready[i] = can_load & (i==g) & !rst. Exactly zero or one bit of in_ready is high.
  - Mode 0: in_ready[sel] may be high while in_valid[sel]=0. That is legal; no transfer occurs.
- Input transfer occurs when in_valid[g] & in_ready[g]. At that clk edge:
  - out_data <= channel g data
  - out_ch <= g
  - out_valid <= 1
- Output drain occurs when out_valid & out_ready with no input transfer in the same cycle. At that clk edge: out_valid <= 0; out_data and out_ch hold their values.
- Simultaneous drain and load in one cycle: the new word replaces the old one and out_valid stays 1. This gives full throughput of 1 word/cycle.
- Latency: one cycle from input transfer to out_valid.
- Backpressure:
  - While out_valid=1 and out_ready=0, out_data and out_ch are stable and all in_ready=0.
  - Input data is never lost or duplicated.
- Round-robin pointer:
  - Updates only on an input transfer in mode 1: rr_ptr <= (g+1) mod NCH.
  - Wrap: g = NCH-1 gives rr_ptr=0.
  - Holds in mode 0.
  - Holds in mode 1 when there is no transfer.
- Mode and sel are sampled combinationally each cycle. A change affects the grant in the same cycle and never corrupts a word already registered.
- Index out of range: if sel >= NCH (non-power-of-2 NCH), there is no grant; in_ready is all zero and no transfer occurs.
- No internal state apart from out_data, out_ch, out_valid and rr_ptr.

Test Plan:
- Reset: hold rst=1 for 2 cycles with all in_valid=1 and out_ready=1 -> out_valid=0, out_data=0, out_ch=0, in_ready=0000 throughout. First transfer occurs the cycle after rst falls.
- Mode 0 stream: mode=0, sel=2, in_valid=1111, channel i data = 8'h10+i, out_ready=1 -> in_ready=0100 every cycle; out_data=8'h12, out_ch=2, out_valid=1 from cycle 1 on, one word per cycle.
- Mode 1 fairness: mode=1, in_valid=1111 constant, out_ready=1 -> out_ch sequence 0,1,2,3,0,1 on consecutive cycles. Sparse case: in_valid=1010 gives sequence 1,3,1,3.
- Backpressure: fill the output with 8'hA5, then hold out_ready=0 for 5 cycles -> out_data=8'hA5 stable, out_valid=1, in_ready=0000. Raise out_ready -> the next word loads in that same cycle and out_valid never drops.
- Round-robin wrap and hold: mode=1, grant channel 3 (rr_ptr -> 0), then in_valid=0000 for 3 cycles, then in_valid=1001 -> next grant is channel 0; rr_ptr did not move while idle.
- Reset mid-operation: out_valid=1 with out_ready=0, then pulse rst for 1 cycle -> out_valid=0 and rr_ptr=0 on the next edge; the held word is dropped, and a new transfer proceeds normally afterwards.

Source files
------------

// File: rtl/mux_nch_stream.sv
// N-channel valid/ready stream multiplexer with a registered output stage.
// Mode 0 forwards the channel picked by sel; mode 1 arbitrates round-robin among valid channels.
module mux_nch_stream #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned NCH   = 4,
  parameter int unsigned SEL_W = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   mode,
  input  logic [SEL_W-1:0]       sel,
  input  logic [NCH*WIDTH-1:0]   in_data,
  input  logic [NCH-1:0]         in_valid,
  output logic [NCH-1:0]         in_ready,
  output logic [WIDTH-1:0]       out_data,
  output logic [SEL_W-1:0]       out_ch,
  output logic                   out_valid,
  input  logic                   out_ready
);

  logic [SEL_W-1:0] rr_ptr;
  logic [SEL_W-1:0] grant;
  logic             grant_ok;
  logic             can_load;
  logic             xfer;
  int unsigned      idx;

  assign can_load = !out_valid || out_ready;

  // grant_ok is low when nothing can be granted (no valid in mode 1, or sel out of range).
  always_comb begin
    grant    = '0;
    grant_ok = 1'b0;
    idx      = 0;
    if (!mode) begin
      grant    = sel;
      grant_ok = (32'(sel) < NCH);
    end else begin
      for (int unsigned k = 0; k < NCH; k++) begin
        idx = (32'(rr_ptr) + k) % NCH;
        if (!grant_ok && in_valid[idx[SEL_W-1:0]]) begin
          grant    = idx[SEL_W-1:0];
          grant_ok = 1'b1;
        end
      end
    end
  end

  always_comb begin
    in_ready = '0;
    if (grant_ok && can_load && !rst) begin
      in_ready[grant] = 1'b1;
    end
  end

  assign xfer = grant_ok && can_load && !rst && in_valid[grant];

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      rr_ptr    <= '0;
    end else begin
      if (xfer) begin
        out_data  <= in_data[grant*WIDTH +: WIDTH];
        out_ch    <= grant;
        out_valid <= 1'b1;
        if (mode) begin
          rr_ptr <= (grant == SEL_W'(NCH - 1)) ? '0 : grant + 1'b1;
        end
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
